// File: rtl/ps2_rx_queue_if.sv
// CPU/pin-side bundle for ps2_rx_queue: raw PS/2 pins, pop/clear strobes,
// and the queue head plus status. Slave side is the receiver.
interface ps2_rx_queue_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic             i_ps2_clk;
    logic             i_ps2_data;
    logic             i_rd;
    logic             i_err_clr;
    logic             o_valid;
    logic [9:0]       o_scancode;
    logic [LVL_W-1:0] o_level;
    logic             o_parity_err;
    logic             o_frame_err;
    logic             o_overflow;

    modport slave (
        input  i_ps2_clk, i_ps2_data, i_rd, i_err_clr,
        output o_valid, o_scancode, o_level, o_parity_err, o_frame_err, o_overflow
    );

    modport master (
        output i_ps2_clk, i_ps2_data, i_rd, i_err_clr,
        input  o_valid, o_scancode, o_level, o_parity_err, o_frame_err, o_overflow
    );
endinterface

// File: rtl/ps2_rx_queue.sv
// PS/2 keyboard receiver: deglitched clock, checked frame FSM with timeout,
// E0/F0 prefix folding and a first-word-fall-through scancode queue.
module ps2_rx_queue #(
    parameter int FIFO_DEPTH     = 8,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input logic           i_clk,
    input logic           i_rst_n,
    ps2_rx_queue_if.slave bus
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = AW + 1;
    localparam int FW    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

    // IDLE: wait start bit | DATA: 8 bits LSB first | PARITY: hold bit | STOP: check, emit
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic          r_filt, r_filt_d;
    logic [FW-1:0] r_filt_cnt;
    logic          r_sample, r_sample_dat;

    state_t        r_state, w_state_nxt;
    logic [7:0]    r_shift;
    logic [2:0]    r_bitcnt;
    logic          r_par;
    logic [TW-1:0] r_tmo;
    logic          w_timeout, w_good, w_par_ev, w_frm_ev;

    logic          r_byte_done;
    logic [7:0]    r_byte;
    logic          r_ext, r_brk;
    logic          r_push;
    logic [9:0]    r_push_code;

    logic [9:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wp, r_rp;
    logic [AW-1:0]    w_rp_next;
    logic [LVL_W-1:0] r_cnt;
    logic [9:0]       r_head, w_head_nxt;
    logic             w_full, w_empty, w_pop, w_wr, w_ovf_ev;

    logic r_par_err, r_frm_err, r_ovf;

    // Synchronisers, clock filter and falling-edge sample event
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_clk_s1     <= 1'b1;
            r_clk_s2     <= 1'b1;
            r_dat_s1     <= 1'b1;
            r_dat_s2     <= 1'b1;
            r_filt       <= 1'b1;
            r_filt_d     <= 1'b1;
            r_filt_cnt   <= '0;
            r_sample     <= 1'b0;
            r_sample_dat <= 1'b1;
        end else begin
            r_clk_s1 <= bus.i_ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= bus.i_ps2_data;
            r_dat_s2 <= r_dat_s1;
            if (r_clk_s2 == r_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
                r_filt     <= r_clk_s2;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + FW'(1);
            end
            r_filt_d     <= r_filt;
            r_sample     <= r_filt_d & ~r_filt;
            r_sample_dat <= r_dat_s2;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good      = 1'b0;
        w_par_ev    = 1'b0;
        w_frm_ev    = 1'b0;
        w_timeout   = (r_state != ST_IDLE) && !r_sample &&
                      (r_tmo == TW'(TIMEOUT_CYCLES - 1));
        if (w_timeout) begin
            w_state_nxt = ST_IDLE;
            w_frm_ev    = 1'b1;
        end else if (r_sample) begin
            case (r_state)
                ST_IDLE:   if (!r_sample_dat) w_state_nxt = ST_DATA;
                ST_DATA:   if (r_bitcnt == 3'd7) w_state_nxt = ST_PARITY;
                ST_PARITY: w_state_nxt = ST_STOP;
                ST_STOP: begin
                    w_state_nxt = ST_IDLE;
                    w_par_ev    = ~(^{r_shift, r_par});
                    w_frm_ev    = ~r_sample_dat;
                    w_good      = (^{r_shift, r_par}) & r_sample_dat;
                end
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_shift     <= '0;
            r_bitcnt    <= '0;
            r_par       <= 1'b0;
            r_tmo       <= '0;
            r_byte_done <= 1'b0;
            r_byte      <= '0;
        end else begin
            if (r_state == ST_IDLE || r_sample || w_timeout) r_tmo <= '0;
            else                                             r_tmo <= r_tmo + TW'(1);

            if (w_timeout) begin
                r_shift  <= '0;
                r_bitcnt <= '0;
            end else if (r_sample) begin
                case (r_state)
                    ST_IDLE: begin
                        r_shift  <= '0;
                        r_bitcnt <= '0;
                    end
                    ST_DATA: begin
                        r_shift  <= {r_sample_dat, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                    end
                    ST_PARITY: r_par <= r_sample_dat;
                    default: ;
                endcase
            end

            r_byte_done <= w_good;
            if (w_good) r_byte <= r_shift;
        end
    end

    // Prefix folding: E0/F0 only arm flags; any receive error drops them
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            r_push      <= 1'b0;
            r_push_code <= '0;
        end else begin
            r_push <= 1'b0;
            if (r_byte_done && r_byte != 8'hE0 && r_byte != 8'hF0) begin
                r_push      <= 1'b1;
                r_push_code <= {r_ext, r_brk, r_byte};
            end
            if (w_par_ev || w_frm_ev) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else if (r_byte_done) begin
                if (r_byte == 8'hE0) begin
                    r_ext <= 1'b1;
                end else if (r_byte == 8'hF0) begin
                    r_brk <= 1'b1;
                end else begin
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                end
            end
        end
    end

    assign w_full    = (r_cnt == LVL_W'(FIFO_DEPTH));
    assign w_empty   = (r_cnt == '0);
    assign w_pop     = bus.i_rd && !w_empty;
    assign w_wr      = r_push && (!w_full || w_pop);
    assign w_ovf_ev  = r_push && w_full && !w_pop;
    assign w_rp_next = r_rp + AW'(1);

    // Registered head keeps the last code visible once the queue drains
    always_comb begin
        w_head_nxt = r_head;
        if (w_empty) begin
            if (w_wr) w_head_nxt = r_push_code;
        end else if (w_pop) begin
            if (r_cnt == LVL_W'(1)) begin
                if (w_wr) w_head_nxt = r_push_code;
            end else begin
                w_head_nxt = r_mem[w_rp_next];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wp] <= r_push_code;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_cnt  <= '0;
            r_head <= '0;
        end else begin
            if (w_wr)  r_wp <= r_wp + AW'(1);
            if (w_pop) r_rp <= w_rp_next;
            case ({w_wr, w_pop})
                2'b10:   r_cnt <= r_cnt + LVL_W'(1);
                2'b01:   r_cnt <= r_cnt - LVL_W'(1);
                default: r_cnt <= r_cnt;
            endcase
            r_head <= w_head_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_par_err <= (r_par_err & ~bus.i_err_clr) | w_par_ev;
            r_frm_err <= (r_frm_err & ~bus.i_err_clr) | w_frm_ev;
            r_ovf     <= (r_ovf     & ~bus.i_err_clr) | w_ovf_ev;
        end
    end

    assign bus.o_valid      = !w_empty;
    assign bus.o_scancode   = r_head;
    assign bus.o_level      = r_cnt;
    assign bus.o_parity_err = r_par_err;
    assign bus.o_frame_err  = r_frm_err;
    assign bus.o_overflow   = r_ovf;
endmodule

// File: tb/tb_ps2_rx_queue.sv
// Randomised and directed bench for ps2_rx_queue against a queue-based
// model of the decoded scancode stream and sticky flags.
module tb_ps2_rx_queue;
    localparam int DEPTH = 4;
    localparam int FLEN  = 4;
    localparam int TMO   = 300;
    localparam int HALF  = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ps2_rx_queue_if #(.FIFO_DEPTH(DEPTH)) bus();

    ps2_rx_queue #(
        .FIFO_DEPTH(DEPTH),
        .FILTER_LEN(FLEN),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [9:0] m_q[$];
    logic [9:0] m_last;
    bit m_ext, m_brk, m_par, m_frm, m_ovf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, "/valid"},    32'(bus.o_valid),      32'(m_q.size() != 0));
        chk({tag, "/level"},    32'(bus.o_level),      32'(m_q.size()));
        chk({tag, "/scancode"}, 32'(bus.o_scancode),   32'(m_last));
        chk({tag, "/par_err"},  32'(bus.o_parity_err), 32'(m_par));
        chk({tag, "/frm_err"},  32'(bus.o_frame_err),  32'(m_frm));
        chk({tag, "/overflow"}, 32'(bus.o_overflow),   32'(m_ovf));
    endtask

    task automatic m_update_head();
        if (m_q.size() > 0) m_last = m_q[0];
    endtask

    task automatic m_reset();
        m_q.delete();
        m_last = '0;
        m_ext = 0; m_brk = 0; m_par = 0; m_frm = 0; m_ovf = 0;
    endtask

    // Reference behaviour of one received frame; rd_too models a pop strobe
    // that lands on the same cycle the frame's code would be queued.
    task automatic m_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                           input bit rd_too);
        if (rd_too && m_q.size() > 0) void'(m_q.pop_front());
        if (bad_par || bad_stop) begin
            if (bad_par)  m_par = 1;
            if (bad_stop) m_frm = 1;
            m_ext = 0;
            m_brk = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            if (m_q.size() < DEPTH) m_q.push_back({m_ext, m_brk, b});
            else                    m_ovf = 1;
            m_ext = 0;
            m_brk = 0;
        end
        m_update_head();
    endtask

    task automatic ps2_bit(input logic b, input bit rd_at_push);
        @(posedge clk); #1;
        bus.i_ps2_data = b;
        repeat (HALF) @(posedge clk);
        #1 bus.i_ps2_clk = 1'b0;
        for (int c = 0; c < HALF; c++) begin
            @(posedge clk); #1;
            bus.i_rd = rd_at_push && (c == FLEN + 4);
        end
        bus.i_ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit rd_at_push);
        logic p;
        p = ~(^b) ^ bad_par;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
        ps2_bit(p, 1'b0);
        ps2_bit(~bad_stop, rd_at_push);
        @(posedge clk); #1 bus.i_ps2_data = 1'b1;
        repeat (HALF) @(posedge clk);
        #1;
        m_frame(b, bad_par, bad_stop, rd_at_push);
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) ps2_bit(b[i], 1'b0);
    endtask

    task automatic pop();
        @(posedge clk); #1 bus.i_rd = 1'b1;
        @(posedge clk); #1 bus.i_rd = 1'b0;
        if (m_q.size() > 0) void'(m_q.pop_front());
        m_update_head();
        @(posedge clk); #1;
    endtask

    task automatic err_clear();
        @(posedge clk); #1 bus.i_err_clr = 1'b1;
        @(posedge clk); #1 bus.i_err_clr = 1'b0;
        m_par = 0; m_frm = 0; m_ovf = 0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        m_reset();
        @(posedge clk); #1;
    endtask

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        bit bp, bs, pp;
        int r;

        bus.i_ps2_clk  = 1'b1;
        bus.i_ps2_data = 1'b1;
        bus.i_rd       = 1'b0;
        bus.i_err_clr  = 1'b0;
        m_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        compare_all("reset");

        send_frame(8'h1C, 0, 0, 0);
        compare_all("byte_1c");
        chk("byte_1c/code", 32'(bus.o_scancode), 32'h01C);
        pop();
        compare_all("pop_1c");

        send_frame(8'hE0, 0, 0, 0);
        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h75, 0, 0, 0);
        compare_all("ext_brk_75");
        chk("ext_brk_75/code", 32'(bus.o_scancode), 32'h375);
        send_frame(8'hE0, 0, 0, 0);
        send_frame(8'h6B, 0, 0, 0);
        compare_all("ext_6b");
        pop();
        compare_all("ext_6b_head");
        chk("ext_6b/code", 32'(bus.o_scancode), 32'h26B);
        pop();

        send_frame(8'h1C, 1, 0, 0);
        compare_all("bad_parity");
        err_clear();
        compare_all("parity_clr");
        send_frame(8'hE0, 0, 0, 0);
        send_frame(8'h1C, 0, 0, 0);
        compare_all("ext_1c");
        pop();

        send_partial(8'h29, 4);
        repeat (TMO + 20) @(posedge clk);
        #1;
        m_frm = 1; m_ext = 0; m_brk = 0;
        compare_all("timeout");
        send_frame(8'h29, 0, 0, 0);
        compare_all("after_timeout");
        pop();
        err_clear();

        for (int i = 0; i < 5; i++) send_frame(8'h11 + 8'(i), 0, 0, 0);
        compare_all("overflow");
        err_clear();
        send_frame(8'h16, 0, 0, 1);
        compare_all("full_push_pop");
        for (int i = 0; i < DEPTH; i++) pop();
        compare_all("drained");

        bus.i_ps2_data = 1'b0;
        for (int g = 0; g < 6; g++) begin
            @(posedge clk); #1 bus.i_ps2_clk = 1'b0;
            repeat (1 + (g % (FLEN - 1))) @(posedge clk);
            #1 bus.i_ps2_clk = 1'b1;
            repeat (8) @(posedge clk);
        end
        #1 bus.i_ps2_data = 1'b1;
        repeat (HALF) @(posedge clk);
        send_frame(8'h5A, 0, 0, 0);
        compare_all("glitch");
        pop();

        send_frame(8'h21, 0, 0, 0);
        send_partial(8'h33, 5);
        do_reset();
        compare_all("mid_reset");
        send_frame(8'h4B, 0, 0, 0);
        compare_all("after_reset");
        pop();

        for (int it = 0; it < 40; it++) begin
            r  = int'($urandom_range(0, 99));
            b  = (r < 15) ? 8'hE0 : (r < 28) ? 8'hF0 : 8'($urandom_range(0, 255));
            bp = ($urandom_range(0, 9) == 0);
            bs = ($urandom_range(0, 9) == 0);
            pp = ($urandom_range(0, 3) == 0);
            send_frame(b, bp, bs, pp);
            compare_all("rand");
            if ($urandom_range(0, 2) == 0) begin
                pop();
                compare_all("rand_pop");
            end
            if ($urandom_range(0, 5) == 0) begin
                err_clear();
                compare_all("rand_clr");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ps2_rx_queue.md
# ps2_rx_queue

Parametrised PS/2 keyboard receiver that replaces the bare frame counter with a filtered, fully checked frame state machine and a buffered scancode queue. It deglitches `ps2_clk` and checks the start bit, odd parity and stop bit. It aborts stalled frames on timeout and folds E0/F0 prefixes into each code. Decoded codes go into a first-word-fall-through FIFO that the CPU-side I/O logic drains with a read strobe.

## Interface
- `FIFO_DEPTH`, default 8: queue entries; power of two, ≥2.
- `FILTER_LEN`, default 4: consecutive identical samples required before the filtered ps2_clk changes; ≥1.
- `TIMEOUT_CYCLES`, default 50000: clk cycles without a sample event, mid-frame, before abort; ≥16.
- `clk` in 1: system clock, the only clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `ps2_clk` in 1: raw PS/2 clock pin, asynchronous.
- `ps2_data` in 1: raw PS/2 data pin, asynchronous.
- `rd` in 1: pop strobe, one pop per high cycle.
- `err_clr` in 1: clears all sticky error flags.
- `valid` out 1: queue non-empty.
- `scancode` out 10: queue head `{ext, brk, code[7:0]}`.
- `level` out $clog2(FIFO_DEPTH)+1: entries held.
- `parity_err` out 1: sticky; a frame had bad odd parity.
- `frame_err` out 1: sticky; bad stop bit or timeout.
- `overflow` out 1: sticky; a code was dropped because the queue was full.

## Operation
- Input path: 2-FF synchroniser on each pin. The filtered clock takes the synced value after FILTER_LEN consecutive equal samples. A registered 1→0 transition of the filtered clock is the one-cycle `sample` event, and the synced ps2_data is captured on that cycle.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: `sample` with data=0 → DATA, bit count 0. `sample` with data=1 is ignored with no error.
  - DATA: shift in LSB first; after the 8th bit → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: a good frame needs an odd number of ones across data+parity and stop=1. Good frame → byte_done. Bad parity → set parity_err. Stop=0 → set frame_err. Every STOP exit → IDLE.
- Timeout: the counter runs in DATA/PARITY/STOP, resets on each `sample`, and is held 0 in IDLE. When it reaches TIMEOUT_CYCLES: → IDLE, set frame_err, discard the partial byte.
- Prefix decoder, on byte_done:
  - E0 sets ext.
  - F0 sets brk.
  - Any other byte pushes `{ext, brk, byte}` and clears both.
  - Any parity, stop or timeout error clears ext and brk.
- FIFO, FWFT: `scancode` shows the head whenever valid=1 and holds its last value when empty.
  - `rd` while empty is ignored.
  - Push while full: the new code is dropped and overflow is set.
  - Push and `rd` in the same cycle while full: both succeed, no overflow, level unchanged.
  - Push and `rd` in the same cycle while empty: push succeeds, rd is ignored.
- Error flags: `err_clr` clears all three. If a new error occurs in the same cycle as `err_clr`, the flag is set.
- Reset, rst_n=0 at a clk edge:
  - FSM → IDLE; bit count, timeout counter, ext and brk → 0.
  - FIFO emptied.
  - Outputs valid=0, scancode=0, level=0, parity_err=0, frame_err=0, overflow=0.
  - Synchroniser and filter → 1, the idle bus level.
  - A frame in flight during reset is lost. The receiver resynchronises on the next start bit after reset is released.

## Timing
- The `sample` event fires FILTER_LEN+3 clk cycles after a clean ps2_clk fall at the pin: 2 sync + FILTER_LEN filter + 1 edge register.
- Glitches shorter than FILTER_LEN cycles produce no event.
- byte_done is registered the cycle after the stop-bit `sample`. The FIFO push happens the next cycle, and valid/level update on the cycle after the push.
- Total latency: stop-bit `sample` to valid=1 is 3 cycles.
- Error flags assert 1 cycle after the offending `sample`, or after the timeout count is reached.
- A pop takes effect at the clk edge where rd=1. The new head appears on `scancode` the following cycle.
- Sustained throughput is one code per PS/2 frame; any rd rate ≥ the frame rate never overflows.

## Test plan
- Frame 0x1C, parity 0, stop 1 → scancode=0x01C, valid=1, level=1, no errors. Then rd → valid=0, level=0.
- Bytes E0, F0, 75 → single entry 0x375, level=1. Then E0, 6B → second entry 0x26B.
- Frame 0x1C with parity bit 1 → nothing queued, parity_err=1. Then err_clr → parity_err=0. A following E0 then 1C frame queues 0x21C.
- Start bit plus 4 data bits, then ps2_clk held high for TIMEOUT_CYCLES → frame_err=1, FSM back in IDLE. The next complete frame 0x29 → 0x029 queued.
- FIFO_DEPTH=4: push 5 codes with no rd → level=4, overflow=1, head = first code. Push and rd in the same cycle while full → level=4, no extra overflow event.
- 1-cycle ps2_clk low glitches with FILTER_LEN=4 → no bit is counted. rst_n=0 during bit 5 of a frame → all outputs at reset values, and the next full frame decodes correctly.
